write_back_stage: RTL and testbench
===================================

// Module: write_back_stage
// PURPOSE
// - Registered, handshaked successor to the combinational write-back unit.
// - Accepts one retiring instruction per cycle from execute/memory.
// - Holds variable-latency load results until the data arrives.
// - Drives a one-cycle register-file write pulse and exports the pending load
//   destination so decode can interlock.
// PARAMETERS
// - DATA_SIZE   32  data / register width in bits
// - GPR_SIZE    5   register-address width in bits
// - MEM_TIMEOUT 64  max cycles waiting for load data; 0 = wait forever
// - CNT_SIZE    7   timeout-counter width; must satisfy 2**CNT_SIZE > MEM_TIMEOUT
// PORTS
// - clk            in   1          rising-edge clock
// - reset_n        in   1          synchronous reset, active low
// - in_valid       in   1          retiring instruction present
// - in_ready       out  1          stage can accept this cycle
// - writeback      in   2          00 NONE, 01 REGISTER, 10 MEMORY, 11 reserved
// - destination    in   GPR_SIZE   target register
// - result         in   DATA_SIZE  ALU result
// - load_size      in   2          00 byte, 01 half, 10 word; 11 treated as word
// - load_signed    in   1          1 = sign-extend, 0 = zero-extend
// - load_offset    in   2          byte offset of the load address
// - mem_valid      in   1          load data valid
// - data_in        in   DATA_SIZE  load data, word aligned
// - write_address  out  GPR_SIZE   register-file write address
// - write_data     out  DATA_SIZE  register-file write data
// - write_enable   out  1          one-cycle write strobe
// - pending_valid  out  1          load outstanding
// - pending_dest   out  GPR_SIZE   destination of outstanding load
// - mem_timeout    out  1          one-cycle pulse: load abandoned
// - illegal_wb     out  1          one-cycle pulse: writeback==11 accepted
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge), regardless of state or mid-load:
//   - state=IDLE; counter=0.
//   - All outputs 0 except in_ready=1.
//   - A pending load is discarded; a later mem_valid produces no write.
// - Acceptance: an instruction is accepted when in_valid & in_ready.
//   - in_ready = (state==IDLE), combinational from state only.
// - FSM IDLE, accept REGISTER: stay IDLE.
//   - Next cycle: write_enable=1, write_address=destination, write_data=result.
//   - Latency is exactly 1 cycle.
// - FSM IDLE, accept MEMORY: go to WAIT_MEM.
//   - Capture destination, load_size, load_signed and load_offset.
//   - Clear the counter. Set pending_valid=1 and pending_dest=destination.
// - FSM IDLE, accept NONE: no write.
// - FSM IDLE, accept reserved (11): no write; illegal_wb=1 next cycle.
// - FSM WAIT_MEM, mem_valid=1: go to IDLE.
//   - Next cycle: write_enable=1, write_address=captured destination,
//     write_data=formatted data_in.
//   - pending_valid=0 in that same cycle; in_ready=1 in that same cycle.
// - FSM WAIT_MEM, no mem_valid:
//   - Counter increments once per cycle.
//   - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT-1: go to IDLE,
//     no write, mem_timeout=1 next cycle, pending_valid=0.
// - mem_valid is ignored in IDLE; stray data is dropped.
// - Destination 0: write_enable is forced to 0 and write_address/write_data
//   are 0. A MEMORY op to register 0 still waits for mem_valid.
// - When write_enable=0, write_address and write_data are 0. This holds for
//   every non-write cycle.
// CONFIGURATION
// - LOAD_EXTEND_EN defined:
//   - The byte/half lane is selected by load_offset (half uses offset[1]).
//   - The lane is then sign- or zero-extended per load_signed.
//   - Word loads pass through.
// - LOAD_EXTEND_EN undefined:
//   - load_size, load_signed and load_offset are ignored.
//   - write_data = data_in unchanged.
// TESTING
// - REGISTER: dest=5, result=0xDEADBEEF
//   -> next cycle write_enable=1, addr=5, data=0xDEADBEEF; in_ready stays 1.
// - MEMORY: dest=3, mem_valid 4 cycles later with data_in=0x000080F0
//   (byte, signed, offset 0)
//   -> in_ready=0 and pending_dest=3 while waiting.
//   -> one write: 0xFFFFFFF0 with LOAD_EXTEND_EN, 0x000080F0 without.
// - Half load: unsigned, offset 2, data_in=0x8001_1234 (LOAD_EXTEND_EN)
//   -> write_data=0x00008001.
// - Timeout: MEM_TIMEOUT=8, MEMORY accepted, no mem_valid
//   -> mem_timeout pulses 8 cycles later; no write; in_ready=1.
// - Destination 0 and reserved op:
//   - REGISTER dest=0 -> write_enable stays 0.
//   - writeback=11 -> illegal_wb pulses 1 cycle; no write.
// - Reset mid-load: assert reset_n=0 during WAIT_MEM, then raise mem_valid
//   -> no write; pending_valid=0; in_ready=1.

Source files
------------

// File: rtl/write_back_stage_if.sv
// Retire / load-data / register-file-write bundle between execute, memory and write-back.
// master: upstream driver of instructions and load data; slave: the write-back stage.
interface write_back_stage_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned GPR_SIZE  = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           writeback;
  logic [GPR_SIZE-1:0]  destination;
  logic [DATA_SIZE-1:0] result;
  logic [1:0]           load_size;
  logic                 load_signed;
  logic [1:0]           load_offset;
  logic                 mem_valid;
  logic [DATA_SIZE-1:0] data_in;
  logic [GPR_SIZE-1:0]  write_address;
  logic [DATA_SIZE-1:0] write_data;
  logic                 write_enable;
  logic                 pending_valid;
  logic [GPR_SIZE-1:0]  pending_dest;
  logic                 mem_timeout;
  logic                 illegal_wb;

  modport master (
    output in_valid, writeback, destination, result,
           load_size, load_signed, load_offset, mem_valid, data_in,
    input  in_ready, write_address, write_data, write_enable,
           pending_valid, pending_dest, mem_timeout, illegal_wb
  );

  modport slave (
    input  in_valid, writeback, destination, result,
           load_size, load_signed, load_offset, mem_valid, data_in,
    output in_ready, write_address, write_data, write_enable,
           pending_valid, pending_dest, mem_timeout, illegal_wb
  );
endinterface

// File: rtl/write_back_stage.sv
// Registered write-back stage: one-cycle register writes, held loads with timeout.
// Optional LOAD_EXTEND_EN: byte/half lane select and sign/zero extension of load data.
module write_back_stage #(
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned GPR_SIZE    = 5,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_SIZE    = 7
) (
  input  logic clk,
  input  logic reset_n,
  write_back_stage_if.slave bus
);

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_REG  = 2'b01;
  localparam logic [1:0] WB_MEM  = 2'b10;
  localparam bit         TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_SIZE-1:0] CNT_LAST =
    CNT_SIZE'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t               state_q, state_d;
  logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
  logic [1:0]           cap_size_q, cap_size_d;
  logic                 cap_signed_q, cap_signed_d;
  logic [1:0]           cap_offset_q, cap_offset_d;
  logic                 write_enable_q, write_enable_d;
  logic [GPR_SIZE-1:0]  write_address_q, write_address_d;
  logic [DATA_SIZE-1:0] write_data_q, write_data_d;
  logic                 pending_valid_q, pending_valid_d;
  logic [GPR_SIZE-1:0]  pending_dest_q, pending_dest_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic                 illegal_wb_q, illegal_wb_d;
  logic [DATA_SIZE-1:0] load_data;

`ifdef LOAD_EXTEND_EN
  // Pick the addressed byte/half lane of the aligned word and extend it
  always_comb begin
    logic [DATA_SIZE-1:0] byte_shift;
    logic [DATA_SIZE-1:0] half_shift;
    byte_shift = bus.data_in >> {cap_offset_q, 3'b000};
    half_shift = bus.data_in >> {cap_offset_q[1], 4'b0000};
    case (cap_size_q)
      2'b00:   load_data = {{(DATA_SIZE-8){cap_signed_q & byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   load_data = {{(DATA_SIZE-16){cap_signed_q & half_shift[15]}}, half_shift[15:0]};
      default: load_data = bus.data_in;
    endcase
  end
`else
  logic unused_load_fields;
  assign unused_load_fields = ^{cap_size_q, cap_signed_q, cap_offset_q};
  assign load_data = bus.data_in;
`endif

  // Next-state and next-output logic; pulses default low every cycle
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cap_size_d      = cap_size_q;
    cap_signed_d    = cap_signed_q;
    cap_offset_d    = cap_offset_q;
    write_enable_d  = 1'b0;
    write_address_d = '0;
    write_data_d    = '0;
    pending_valid_d = pending_valid_q;
    pending_dest_d  = pending_dest_q;
    mem_timeout_d   = 1'b0;
    illegal_wb_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.writeback)
            WB_REG: begin
              if (bus.destination != '0) begin
                write_enable_d  = 1'b1;
                write_address_d = bus.destination;
                write_data_d    = bus.result;
              end
            end
            WB_MEM: begin
              state_d         = WAIT_MEM;
              cnt_d           = '0;
              cap_size_d      = bus.load_size;
              cap_signed_d    = bus.load_signed;
              cap_offset_d    = bus.load_offset;
              pending_valid_d = 1'b1;
              pending_dest_d  = bus.destination;
            end
            WB_NONE: ;
            default: illegal_wb_d = 1'b1;
          endcase
        end
      end
      WAIT_MEM: begin
        // pending_dest doubles as the captured load destination
        if (bus.mem_valid) begin
          state_d         = IDLE;
          pending_valid_d = 1'b0;
          pending_dest_d  = '0;
          if (pending_dest_q != '0) begin
            write_enable_d  = 1'b1;
            write_address_d = pending_dest_q;
            write_data_d    = load_data;
          end
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d         = IDLE;
          mem_timeout_d   = 1'b1;
          pending_valid_d = 1'b0;
          pending_dest_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      cap_size_q      <= '0;
      cap_signed_q    <= 1'b0;
      cap_offset_q    <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      pending_valid_q <= 1'b0;
      pending_dest_q  <= '0;
      mem_timeout_q   <= 1'b0;
      illegal_wb_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cap_size_q      <= cap_size_d;
      cap_signed_q    <= cap_signed_d;
      cap_offset_q    <= cap_offset_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      pending_valid_q <= pending_valid_d;
      pending_dest_q  <= pending_dest_d;
      mem_timeout_q   <= mem_timeout_d;
      illegal_wb_q    <= illegal_wb_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.pending_valid = pending_valid_q;
  assign bus.pending_dest  = pending_dest_q;
  assign bus.mem_timeout   = mem_timeout_q;
  assign bus.illegal_wb    = illegal_wb_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed cases then random traffic
// against a transaction-level reference model (honours LOAD_EXTEND_EN).
module tb_write_back_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned GW = 5;
  localparam int unsigned TO = 8;
`ifdef LOAD_EXTEND_EN
  localparam bit USE_EXT = 1'b1;
`else
  localparam bit USE_EXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  write_back_stage_if #(.DATA_SIZE(DW), .GPR_SIZE(GW)) bus ();

  write_back_stage #(
    .DATA_SIZE(DW), .GPR_SIZE(GW), .MEM_TIMEOUT(TO), .CNT_SIZE(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: an outstanding-load record plus expected outputs
  bit            m_busy;
  int unsigned   m_waited;
  logic [GW-1:0] m_dest;
  logic [1:0]    m_size;
  logic          m_sgn;
  logic [1:0]    m_off;
  logic          e_we, e_to, e_ill;
  logic [GW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [1:0] sz,
                                      input logic sg, input logic [1:0] off);
    int unsigned lane, ext;
    case (sz)
      2'd0: begin
        lane = (raw >> (8 * off)) % 256;
        ext  = (sg && lane >= 128) ? lane + 32'hFFFF_FF00 : lane;
      end
      2'd1: begin
        lane = (raw >> (16 * (off / 2))) % 65536;
        ext  = (sg && lane >= 32768) ? lane + 32'hFFFF_0000 : lane;
      end
      default: begin
        lane = raw;
        ext  = lane;
      end
    endcase
    return USE_EXT ? ext : raw;
  endfunction

  task automatic model_edge();
    e_we = 1'b0; e_addr = '0; e_data = '0; e_to = 1'b0; e_ill = 1'b0;
    if (!reset_n) begin
      m_busy = 1'b0;
      m_waited = 0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        if (bus.writeback == 2'd1 && bus.destination != 0) begin
          e_we = 1'b1; e_addr = bus.destination; e_data = bus.result;
        end else if (bus.writeback == 2'd2) begin
          m_busy = 1'b1; m_waited = 0; m_dest = bus.destination;
          m_size = bus.load_size; m_sgn = bus.load_signed; m_off = bus.load_offset;
        end else if (bus.writeback == 2'd3) begin
          e_ill = 1'b1;
        end
      end
    end else if (bus.mem_valid) begin
      m_busy = 1'b0;
      if (m_dest != 0) begin
        e_we = 1'b1; e_addr = m_dest; e_data = fmt(bus.data_in, m_size, m_sgn, m_off);
      end
    end else begin
      m_waited++;
      if (TO != 0 && m_waited == TO) begin
        m_busy = 1'b0;
        e_to = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [GW-1:0] d,
                       input logic [DW-1:0] r, input logic [1:0] ls, input logic sg,
                       input logic [1:0] off, input logic mv, input logic [DW-1:0] din);
    bus.in_valid = v; bus.writeback = wb; bus.destination = d; bus.result = r;
    bus.load_size = ls; bus.load_signed = sg; bus.load_offset = off;
    bus.mem_valid = mv; bus.data_in = din;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, '0, '0, 2'd0, 1'b0, 2'd0, 1'b0, '0);
  endtask

  // One clock: advance the model, then compare every output just after the edge
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("write_enable",  64'(bus.write_enable),  64'(e_we));
    check_eq("write_address", 64'(bus.write_address), 64'(e_addr));
    check_eq("write_data",    64'(bus.write_data),    64'(e_data));
    check_eq("mem_timeout",   64'(bus.mem_timeout),   64'(e_to));
    check_eq("illegal_wb",    64'(bus.illegal_wb),    64'(e_ill));
    check_eq("in_ready",      64'(bus.in_ready),      64'(!m_busy));
    check_eq("pending_valid", 64'(bus.pending_valid), 64'(m_busy));
    check_eq("pending_dest",  64'(bus.pending_dest),  m_busy ? 64'(m_dest) : 64'd0);
  endtask

  initial begin
    m_busy = 1'b0; m_waited = 0; m_dest = '0; m_size = '0; m_sgn = 1'b0; m_off = '0;
    reset_n = 1'b0;
    idle();
    cycle();
    cycle();
    check_eq("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("reset_write_enable", 64'(bus.write_enable), 64'd0);
    reset_n = 1'b1;

    // Register write, one-cycle latency
    drive(1'b1, 2'd1, 5'd5, 32'hDEADBEEF, 2'd0, 1'b0, 2'd0, 1'b0, '0);
    cycle();
    check_eq("reg_data", 64'(bus.write_data), 64'h0000_0000_DEAD_BEEF);
    check_eq("reg_addr", 64'(bus.write_address), 64'd5);
    idle();
    cycle();

    // Signed byte load to r3, data four cycles after acceptance
    drive(1'b1, 2'd2, 5'd3, '0, 2'd0, 1'b1, 2'd0, 1'b0, '0);
    cycle();
    idle();
    repeat (3) begin
      cycle();
      check_eq("wait_pending_dest", 64'(bus.pending_dest), 64'd3);
      check_eq("wait_in_ready", 64'(bus.in_ready), 64'd0);
    end
    drive(1'b0, 2'd0, '0, '0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h0000_80F0);
    cycle();
    check_eq("byte_load_data", 64'(bus.write_data), USE_EXT ? 64'hFFFF_FFF0 : 64'h0000_80F0);
    idle();
    cycle();

    // Unsigned half load from offset 2
    drive(1'b1, 2'd2, 5'd9, '0, 2'd1, 1'b0, 2'd2, 1'b0, '0);
    cycle();
    drive(1'b0, 2'd0, '0, '0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h8001_1234);
    cycle();
    check_eq("half_load_data", 64'(bus.write_data), USE_EXT ? 64'h0000_8001 : 64'h8001_1234);
    idle();
    cycle();

    // Timeout: pulse exactly TO cycles after acceptance
    drive(1'b1, 2'd2, 5'd7, '0, 2'd2, 1'b0, 2'd0, 1'b0, '0);
    cycle();
    idle();
    repeat (TO - 1) cycle();
    check_eq("timeout_early", 64'(bus.mem_timeout), 64'd0);
    cycle();
    check_eq("timeout_pulse", 64'(bus.mem_timeout), 64'd1);
    check_eq("timeout_ready", 64'(bus.in_ready), 64'd1);
    cycle();

    // Destination 0 and reserved op
    drive(1'b1, 2'd1, 5'd0, 32'h1234_5678, 2'd0, 1'b0, 2'd0, 1'b0, '0);
    cycle();
    check_eq("dest0_no_write", 64'(bus.write_enable), 64'd0);
    drive(1'b1, 2'd3, 5'd4, 32'h1111_2222, 2'd0, 1'b0, 2'd0, 1'b0, '0);
    cycle();
    check_eq("illegal_pulse", 64'(bus.illegal_wb), 64'd1);
    idle();
    cycle();

    // Reset during an outstanding load discards it
    drive(1'b1, 2'd2, 5'd6, '0, 2'd2, 1'b0, 2'd0, 1'b0, '0);
    cycle();
    idle();
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    drive(1'b0, 2'd0, '0, '0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hCAFE_F00D);
    cycle();
    check_eq("reset_load_no_write", 64'(bus.write_enable), 64'd0);
    check_eq("reset_load_ready", 64'(bus.in_ready), 64'd1);

    // Random traffic
    repeat (3000) begin
      reset_n = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), $urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
